irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//   Interrupt controller in front of the pipeline's exception/CP0 logic. Synchronises the
//   external interrupt lines and latches rising edges as pending events. Masks and arbitrates
//   them, then runs a req/ack/eret handshake so that one interrupt at a time is presented to
//   the pipeline. No nesting: a new request is issued only after the handler returns (eret).
// PARAMETERS
//   N_IRQ        2   number of external interrupt lines
//   ID_W         1   width of irq_id; must be >= clog2(N_IRQ)
//   SYNC_STAGES  2   synchroniser flops per line (>= 2)
// PORTS
//   clk_gl      in   1      global clock
//   rst_n       in   1      synchronous reset, active-low
//   irq_in      in   N_IRQ  external interrupt lines, asynchronous, level-held by source
//   ie          in   1      global interrupt enable (CP0 Status.IE)
//   mask_we     in   1      write strobe for mask register
//   mask_wdata  in   N_IRQ  new mask value, bit=1 enables the line
//   ack         in   1      pipeline has taken the presented interrupt (exception committed)
//   eret        in   1      handler returned; ends service
//   irq_req     out  1      interrupt request to the pipeline
//   irq_id      out  ID_W   index of the requested/serviced line
//   pending     out  N_IRQ  latched pending events (masked lines included)
//   mask        out  N_IRQ  current mask register
//   in_service  out  1      handler currently running
// BEHAVIOUR
//   Reset (rst_n==0 at posedge clk_gl): sync chains, edge history, pending, mask = 0.
//     State = IDLE; irq_req, irq_id and in_service = 0. Reset mid-REQ/SERVICE drops
//     everything, and a line still held high does NOT re-trigger: history resets to 0,
//     but the line must pass through the sync chain and appear as a new 0->1 edge.
//   Sync/edge: each line passes through SYNC_STAGES flops. rise[i] = sync[i] & ~prev[i].
//     A 0->1 on irq_in sets pending[i] SYNC_STAGES+1 cycles later. Level held = one event.
//   Pending: set by rise[i]; cleared for bit irq_id on accepted ack. Set and clear on the
//     same bit in the same cycle -> set wins (new event). Masked lines still latch pending.
//   mask: written on mask_we, visible the next cycle.
//   Arbitration: eligible = pending & mask, gated by ie. Lowest index = highest priority.
//   FSM (Moore outputs):
//     IDLE    : irq_req=0, in_service=0. If ie && |eligible -> REQ.
//               irq_id latched from the winner on this transition.
//     REQ     : irq_req=1; irq_id stable, with no re-arbitration.
//               ack -> SERVICE and clear pending[irq_id].
//               else if !ie or !mask[irq_id] -> IDLE (withdraw); pending is kept.
//               ack together with a withdraw condition in the same cycle -> ack wins.
//     SERVICE : irq_req=0, in_service=1, irq_id held.
//               eret -> IDLE; a new request can appear the cycle after.
//   ack outside REQ and eret outside SERVICE are ignored.
//   Latency: pending set -> irq_req high is 1 cycle (IDLE->REQ edge). ack -> in_service is 1.
// TESTING
//   1 rst_n=0 for 25 cycles, irq_in=2'b11 -> all outputs 0. After release, no request:
//     mask=0 and the history comparison has no edge until the sync chain fills.
//   2 mask=2'b11, ie=1, irq_in 2'b00->2'b10 held 100 cycles -> pending=2'b10 at +3 cycles.
//     irq_req=1, irq_id=1 at +4. ack -> pending=0, in_service=1.
//     No second request while the line stays held. eret -> IDLE, irq_req stays 0.
//   3 irq_in 2'b00->2'b11 in one cycle -> irq_id=0 first. ack then eret -> REQ again with
//     irq_id=1 the cycle after eret.
//   4 mask=2'b01, edge on line 1 -> pending=2'b10, irq_req stays 0.
//     Write mask=2'b11 -> irq_req=1, irq_id=1 two cycles after mask_we.
//   5 In REQ with irq_id=1, drop ie before ack -> irq_req=0 next cycle, pending=2'b10 kept.
//     Raise ie -> request re-issued. Also: ack with ie falling in the same cycle -> SERVICE.
//   6 In SERVICE, pulse rst_n=0 one cycle -> in_service=0, pending=0, mask=0 next cycle.
//     A stray eret or ack after reset -> no state change.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller in front of the exception/CP0 logic.
// Synchronises external interrupt lines and latches rising edges as pending
// events. It masks and prioritises them (lowest index wins), then presents one
// interrupt at a time to the pipeline with a req/ack/eret handshake. There is
// no nesting: a new request is issued only after the handler returns.
module irq_ctrl #(
  parameter int N_IRQ       = 2,
  parameter int ID_W        = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_gl,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             ie,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             ack,
  input  logic             eret,
  output logic             irq_req,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] mask,
  output logic             in_service
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  // Synchroniser chain: stage 0 samples the pins, the last stage feeds edge detection.
  logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q, sync_d;
  logic [N_IRQ-1:0]                  prev_q, prev_d;
  logic [N_IRQ-1:0]                  rise;

  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] clear_pend;
  logic [N_IRQ-1:0] eligible;

  logic            win_valid;
  logic [ID_W-1:0] win_id;

  state_t          state_q, state_d;
  logic [ID_W-1:0] irq_id_q, irq_id_d;

  // Shift the synchroniser chain and detect 0->1 transitions on its output.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default at the top, so
    // no path leaves it unassigned and no latch is inferred.
    sync_d    = sync_q;
    sync_d[0] = irq_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
    rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  // Mask register update and eligibility (ie gates everything).
  always_comb begin
    mask_d   = mask_we ? mask_wdata : mask_q;
    eligible = ie ? (pending_q & mask_q) : '0;
  end

  // Fixed-priority pick: the lowest eligible index wins.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_valid = 1'b1;
        win_id    = ID_W'(i);
      end
    end
  end

  // Handshake FSM next-state logic; also produces the pending-clear on ack.
  always_comb begin
    state_d    = state_q;
    irq_id_d   = irq_id_q;
    clear_pend = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d  = ST_REQ;
          irq_id_d = win_id;
        end
      end
      ST_REQ: begin
        // ack takes precedence over a simultaneous withdraw condition.
        if (ack) begin
          state_d              = ST_SERVICE;
          clear_pend[irq_id_q] = 1'b1;
        end else if (!ie || !mask_q[irq_id_q]) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (eret) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pending update: a fresh edge on the same bit overrides the ack clear.
  always_comb begin
    pending_d = (pending_q & ~clear_pend) | rise;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_gl) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update
    // together from pre-edge values; blocking here would create order races.
    if (!rst_n) begin
      sync_q    <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      state_q   <= ST_IDLE;
      irq_id_q  <= '0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      state_q   <= state_d;
      irq_id_q  <= irq_id_d;
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    irq_req    = (state_q == ST_REQ);
    in_service = (state_q == ST_SERVICE);
    irq_id     = irq_id_q;
    pending    = pending_q;
    mask       = mask_q;
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: reset behaviour, edge latency, priority,
// masking, withdraw, and set-over-clear, against hand-computed expectations.
module tb_irq_ctrl;

  logic       clk_gl = 1'b0;
  logic       rst_n;
  logic [1:0] irq_in;
  logic       ie;
  logic       mask_we;
  logic [1:0] mask_wdata;
  logic       ack;
  logic       eret;
  logic       irq_req;
  logic [0:0] irq_id;
  logic [1:0] pending;
  logic [1:0] mask;
  logic       in_service;

  int checks = 0;
  int errors = 0;

  irq_ctrl #(.N_IRQ(2), .ID_W(1), .SYNC_STAGES(2)) dut (
    .clk_gl     (clk_gl),
    .rst_n      (rst_n),
    .irq_in     (irq_in),
    .ie         (ie),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ack        (ack),
    .eret       (eret),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .pending    (pending),
    .mask       (mask),
    .in_service (in_service)
  );

  always #5 clk_gl = ~clk_gl;

  typedef struct {
    logic [1:0] irq;
    logic       ie;
    logic       mwe;
    logic [1:0] mwd;
    logic       ack;
    logic       eret;
    logic       req;
    logic       id;
    logic [1:0] pend;
    logic [1:0] msk;
    logic       insvc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic [1:0] irq, input logic ie_i, input logic mwe,
                             input logic [1:0] mwd, input logic ack_i, input logic eret_i,
                             input logic req, input logic id, input logic [1:0] pend,
                             input logic [1:0] msk, input logic insvc);
    vec_t r;
    r.irq = irq; r.ie = ie_i; r.mwe = mwe; r.mwd = mwd; r.ack = ack_i; r.eret = eret_i;
    r.req = req; r.id = id; r.pend = pend; r.msk = msk; r.insvc = insvc;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_gl);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic req, input logic id,
                           input logic [1:0] pend, input logic [1:0] msk, input logic insvc);
    check({tag, ".irq_req"},    32'(irq_req),    32'(req));
    check({tag, ".irq_id"},     32'(irq_id),     32'(id));
    check({tag, ".pending"},    32'(pending),    32'(pend));
    check({tag, ".mask"},       32'(mask),       32'(msk));
    check({tag, ".in_service"}, 32'(in_service), 32'(insvc));
  endtask

  initial begin
    int bad;

    rst_n = 1'b0; irq_in = 2'b11; ie = 1'b0; mask_we = 1'b0; mask_wdata = 2'b00;
    ack = 1'b0; eret = 1'b0;

    // Test 1: long reset with lines high, then no request after release.
    repeat (25) tick();
    check_all("t1_reset", 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    rst_n = 1'b1;
    tick(); tick();
    check_all("t1_release", 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    tick();
    check("t1_noreq", 32'(irq_req), 32'd0);

    // Clean restart with lines low.
    rst_n = 1'b0; irq_in = 2'b00;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Test 2: single edge on line 1, latency and no re-trigger while held.
    mask_we = 1'b1; mask_wdata = 2'b11; ie = 1'b1;
    tick();
    mask_we = 1'b0;
    check("t2_mask", 32'(mask), 32'h3);
    irq_in = 2'b10;
    tick(); tick();
    check("t2_pend_p2", 32'(pending), 32'h0);
    tick();
    check("t2_pend_p3", 32'(pending), 32'h2);
    check("t2_req_p3", 32'(irq_req), 32'd0);
    tick();
    check_all("t2_req_p4", 1'b1, 1'b1, 2'b10, 2'b11, 1'b0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_all("t2_ack", 1'b0, 1'b1, 2'b00, 2'b11, 1'b1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (irq_req !== 1'b0 || pending !== 2'b00 || in_service !== 1'b1) bad++;
    end
    check("t2_held_service", 32'(bad), 32'd0);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check_all("t2_eret", 1'b0, 1'b1, 2'b00, 2'b11, 1'b0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (irq_req !== 1'b0 || pending !== 2'b00) bad++;
    end
    check("t2_no_rereq", 32'(bad), 32'd0);
    irq_in = 2'b00;
    repeat (4) tick();

    // Tests 3-5 and set-over-clear, one row per clock cycle.
    //                irq   ie  mwe mwd   ack eret   req id pend   mask  insvc
    vecs.push_back(v(2'b11, 1, 0, 2'b00, 0, 0,    0, 1, 2'b00, 2'b11, 0)); // 0
    vecs.push_back(v(2'b11, 1, 0, 2'b00, 0, 0,    0, 1, 2'b00, 2'b11, 0)); // 1
    vecs.push_back(v(2'b11, 1, 0, 2'b00, 0, 0,    0, 1, 2'b11, 2'b11, 0)); // 2 both pending
    vecs.push_back(v(2'b11, 1, 0, 2'b00, 0, 0,    1, 0, 2'b11, 2'b11, 0)); // 3 line 0 first
    vecs.push_back(v(2'b11, 1, 0, 2'b00, 1, 0,    0, 0, 2'b10, 2'b11, 1)); // 4 ack
    vecs.push_back(v(2'b11, 1, 0, 2'b00, 0, 0,    0, 0, 2'b10, 2'b11, 1)); // 5
    vecs.push_back(v(2'b11, 1, 0, 2'b00, 0, 1,    0, 0, 2'b10, 2'b11, 0)); // 6 eret
    vecs.push_back(v(2'b11, 1, 0, 2'b00, 0, 0,    1, 1, 2'b10, 2'b11, 0)); // 7 line 1 next
    vecs.push_back(v(2'b11, 1, 0, 2'b00, 1, 0,    0, 1, 2'b00, 2'b11, 1)); // 8
    vecs.push_back(v(2'b11, 1, 0, 2'b00, 0, 1,    0, 1, 2'b00, 2'b11, 0)); // 9
    vecs.push_back(v(2'b00, 1, 0, 2'b00, 0, 0,    0, 1, 2'b00, 2'b11, 0)); // 10
    vecs.push_back(v(2'b00, 1, 0, 2'b00, 0, 0,    0, 1, 2'b00, 2'b11, 0)); // 11
    vecs.push_back(v(2'b00, 1, 0, 2'b00, 0, 0,    0, 1, 2'b00, 2'b11, 0)); // 12
    vecs.push_back(v(2'b00, 1, 1, 2'b01, 0, 0,    0, 1, 2'b00, 2'b01, 0)); // 13 mask=01
    vecs.push_back(v(2'b10, 1, 0, 2'b00, 0, 0,    0, 1, 2'b00, 2'b01, 0)); // 14
    vecs.push_back(v(2'b10, 1, 0, 2'b00, 0, 0,    0, 1, 2'b00, 2'b01, 0)); // 15
    vecs.push_back(v(2'b10, 1, 0, 2'b00, 0, 0,    0, 1, 2'b10, 2'b01, 0)); // 16 masked pending
    vecs.push_back(v(2'b10, 1, 0, 2'b00, 0, 0,    0, 1, 2'b10, 2'b01, 0)); // 17
    vecs.push_back(v(2'b10, 1, 1, 2'b11, 0, 0,    0, 1, 2'b10, 2'b11, 0)); // 18 unmask
    vecs.push_back(v(2'b10, 1, 0, 2'b00, 0, 0,    1, 1, 2'b10, 2'b11, 0)); // 19 req
    vecs.push_back(v(2'b10, 0, 0, 2'b00, 0, 0,    0, 1, 2'b10, 2'b11, 0)); // 20 withdraw
    vecs.push_back(v(2'b10, 0, 0, 2'b00, 0, 0,    0, 1, 2'b10, 2'b11, 0)); // 21
    vecs.push_back(v(2'b10, 1, 0, 2'b00, 0, 0,    1, 1, 2'b10, 2'b11, 0)); // 22 re-issue
    vecs.push_back(v(2'b10, 0, 0, 2'b00, 1, 0,    0, 1, 2'b00, 2'b11, 1)); // 23 ack beats !ie
    vecs.push_back(v(2'b10, 1, 0, 2'b00, 1, 0,    0, 1, 2'b00, 2'b11, 1)); // 24 stray ack
    vecs.push_back(v(2'b10, 1, 0, 2'b00, 0, 1,    0, 1, 2'b00, 2'b11, 0)); // 25
    vecs.push_back(v(2'b11, 1, 0, 2'b00, 0, 0,    0, 1, 2'b00, 2'b11, 0)); // 26
    vecs.push_back(v(2'b11, 1, 0, 2'b00, 0, 0,    0, 1, 2'b00, 2'b11, 0)); // 27
    vecs.push_back(v(2'b10, 1, 0, 2'b00, 0, 0,    0, 1, 2'b01, 2'b11, 0)); // 28
    vecs.push_back(v(2'b10, 1, 0, 2'b00, 0, 0,    1, 0, 2'b01, 2'b11, 0)); // 29
    vecs.push_back(v(2'b11, 1, 0, 2'b00, 0, 0,    1, 0, 2'b01, 2'b11, 0)); // 30
    vecs.push_back(v(2'b11, 1, 0, 2'b00, 0, 0,    1, 0, 2'b01, 2'b11, 0)); // 31
    vecs.push_back(v(2'b11, 1, 0, 2'b00, 1, 0,    0, 0, 2'b01, 2'b11, 1)); // 32 set beats clear
    vecs.push_back(v(2'b11, 1, 0, 2'b00, 0, 1,    0, 0, 2'b01, 2'b11, 0)); // 33
    vecs.push_back(v(2'b11, 1, 0, 2'b00, 0, 0,    1, 0, 2'b01, 2'b11, 0)); // 34
    vecs.push_back(v(2'b11, 1, 0, 2'b00, 1, 0,    0, 0, 2'b00, 2'b11, 1)); // 35
    vecs.push_back(v(2'b11, 1, 0, 2'b00, 0, 1,    0, 0, 2'b00, 2'b11, 0)); // 36
    vecs.push_back(v(2'b11, 1, 0, 2'b00, 0, 0,    0, 0, 2'b00, 2'b11, 0)); // 37

    foreach (vecs[i]) begin
      irq_in = vecs[i].irq; ie = vecs[i].ie; mask_we = vecs[i].mwe;
      mask_wdata = vecs[i].mwd; ack = vecs[i].ack; eret = vecs[i].eret;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].req, vecs[i].id, vecs[i].pend,
                vecs[i].msk, vecs[i].insvc);
    end
    mask_we = 1'b0; ack = 1'b0; eret = 1'b0; ie = 1'b1;

    // Test 6: reset pulse while in SERVICE, then stray eret/ack.
    irq_in = 2'b00;
    repeat (3) tick();
    irq_in = 2'b10;
    repeat (4) tick();
    check_all("t6_req", 1'b1, 1'b1, 2'b10, 2'b11, 1'b0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_all("t6_service", 1'b0, 1'b1, 2'b00, 2'b11, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_all("t6_reset", 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check_all("t6_stray_eret", 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_all("t6_stray_ack", 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
